// File: rtl/cgol_engine.sv
// cgol_engine -- Conway's Game of Life (B3/S23) generation engine.
//
// Holds a HEIGHT x WIDTH grid in two bit arrays: cur (visible state) and
// nxt (generation under construction). A step request sweeps one row per
// cycle through COMPUTE, then COMMIT copies nxt into cur in a single cycle,
// so the display never shows a partially computed generation.
//
// Configuration macro: CGOL_TORUS_EN
//   defined   - neighbour indices wrap on both axes (toroidal grid)
//   undefined - cells outside the grid count as dead
//
// Ports:
//   ph1        in   sole clock, rising edge
//   reset      in   synchronous, active-high; clears grid, FSM and status
//   load_en    in   write load_data into cur[load_addr] (IDLE only)
//   load_addr  in   row index for the load; indices >= HEIGHT are ignored
//   load_data  in   row contents, bit c = column c, 1 = alive
//   step_req   in   request one generation (ignored while busy)
//   busy       out  high in COMPUTE and COMMIT
//   done       out  one-cycle pulse in the first IDLE cycle after COMMIT
//   stable     out  last committed generation equalled its predecessor
//   gen_count  out  committed generations, modulo 2^16
//   row        out  one-hot display row select (free-running scan)
//   col        out  cur contents of the selected row
module cgol_engine #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int REGBITS = 3
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               load_en,
  input  logic [REGBITS-1:0] load_addr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               step_req,
  output logic               busy,
  output logic               done,
  output logic               stable,
  output logic [15:0]        gen_count,
  output logic [HEIGHT-1:0]  row,
  output logic [WIDTH-1:0]   col
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]         state;
  logic [REGBITS-1:0] rcnt;
  logic [REGBITS-1:0] scan;
  logic [WIDTH-1:0]   cur [HEIGHT];
  logic [WIDTH-1:0]   nxt [HEIGHT];

  logic [WIDTH-1:0]   up_row, mid_row, dn_row;
  logic [WIDTH-1:0]   u_l, u_r, m_l, m_r, d_l, d_r;
  logic [WIDTH-1:0]   new_row;
  logic               same;

  // shl(v)[c] = v[c-1], shr(v)[c] = v[c+1]; the vacated edge bit is either
  // the wrapped-around column or a dead cell.
  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v);
`ifdef CGOL_TORUS_EN
    return {v[WIDTH-2:0], v[WIDTH-1]};
`else
    return {v[WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v);
`ifdef CGOL_TORUS_EN
    return {v[0], v[WIDTH-1:1]};
`else
    return {1'b0, v[WIDTH-1:1]};
`endif
  endfunction

  // Rows r-1, r, r+1 around the row being computed.
  always_comb begin
    up_row  = '0;
    mid_row = '0;
    dn_row  = '0;
    for (int unsigned i = 0; i < HEIGHT; i++) begin
      if (rcnt == REGBITS'(i)) begin
        mid_row = cur[i];
        up_row  = cur[(i + HEIGHT - 1) % HEIGHT];
        dn_row  = cur[(i + 1) % HEIGHT];
`ifndef CGOL_TORUS_EN
        if (i == 0)          up_row = '0;
        if (i == HEIGHT - 1) dn_row = '0;
`endif
      end
    end
  end

  assign u_l = shl(up_row);
  assign u_r = shr(up_row);
  assign m_l = shl(mid_row);
  assign m_r = shr(mid_row);
  assign d_l = shl(dn_row);
  assign d_r = shr(dn_row);

  // Eight-neighbour count per column (cell itself excluded), then B3/S23.
  always_comb begin
    logic [3:0] cnt;
    cnt     = '0;
    new_row = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      cnt = {3'b000, u_l[c]} + {3'b000, up_row[c]} + {3'b000, u_r[c]} +
            {3'b000, m_l[c]} + {3'b000, m_r[c]} +
            {3'b000, d_l[c]} + {3'b000, dn_row[c]} + {3'b000, d_r[c]};
      new_row[c] = (cnt == 4'd3) | (mid_row[c] & (cnt == 4'd2));
    end
  end

  always_comb begin
    same = 1'b1;
    for (int unsigned i = 0; i < HEIGHT; i++) begin
      if (nxt[i] != cur[i]) same = 1'b0;
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      rcnt      <= '0;
      scan      <= '0;
      done      <= 1'b0;
      stable    <= 1'b0;
      gen_count <= '0;
      for (int unsigned i = 0; i < HEIGHT; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      scan <= (scan == REGBITS'(HEIGHT - 1)) ? '0 : scan + 1'b1;
      case (state)
        IDLE: begin
          // Address match against 0..HEIGHT-1 only, so out-of-range
          // addresses fall through without a write.
          if (load_en) begin
            for (int unsigned i = 0; i < HEIGHT; i++) begin
              if (load_addr == REGBITS'(i)) cur[i] <= load_data;
            end
          end
          if (step_req) begin
            state <= COMPUTE;
            rcnt  <= '0;
          end
        end
        COMPUTE: begin
          for (int unsigned i = 0; i < HEIGHT; i++) begin
            if (rcnt == REGBITS'(i)) nxt[i] <= new_row;
          end
          if (rcnt == REGBITS'(HEIGHT - 1)) begin
            state <= COMMIT;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < HEIGHT; i++) begin
            cur[i] <= nxt[i];
          end
          stable    <= same;
          gen_count <= gen_count + 16'd1;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    row = '0;
    col = '0;
    for (int unsigned i = 0; i < HEIGHT; i++) begin
      if (scan == REGBITS'(i)) begin
        row[i] = 1'b1;
        col    = cur[i];
      end
    end
  end

endmodule

// File: tb/tb_cgol_engine.sv
// Self-checking bench for cgol_engine (8x8). A plain-arithmetic Life model
// and an independent scan counter supply every expected value.
module tb_cgol_engine;

  localparam int W = 8;
  localparam int H = 8;

  typedef logic [W-1:0] grid_t [H];

  logic       ph1;
  logic       reset;
  logic       load_en;
  logic [2:0] load_addr;
  logic [7:0] load_data;
  logic       step_req;
  logic       busy;
  logic       done;
  logic       stable;
  logic [15:0] gen_count;
  logic [7:0] row;
  logic [7:0] col;

  cgol_engine #(.WIDTH(8), .HEIGHT(8), .REGBITS(3)) dut (
    .ph1(ph1), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .step_req(step_req), .busy(busy), .done(done),
    .stable(stable), .gen_count(gen_count), .row(row), .col(col)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  grid_t model;
  int    gen_exp;
  bit    stable_exp;
  int    n_cmp;
  int    n_fail;
  int    tb_scan;

  initial tb_scan = 0;
  always @(posedge ph1) begin
    if (reset) tb_scan <= 0;
    else       tb_scan <= (tb_scan + 1) % H;
  end

  function automatic grid_t next_gen(input grid_t g);
    grid_t n;
    int cnt, rr, cc;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef CGOL_TORUS_EN
              rr = (rr + H) % H;
              cc = (cc + W) % W;
              cnt += int'(g[rr][cc]);
`else
              if (rr >= 0 && rr < H && cc >= 0 && cc < W) cnt += int'(g[rr][cc]);
`endif
            end
          end
        end
        n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic bit grids_eq(input grid_t a, input grid_t b);
    for (int r = 0; r < H; r++) if (a[r] != b[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; load_en = 1'b0; step_req = 1'b0;
    @(posedge ph1); #1;
    reset = 1'b0;
    for (int r = 0; r < H; r++) model[r] = '0;
    gen_exp = 0;
    stable_exp = 1'b0;
  endtask

  task automatic load_row(input logic [2:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge ph1); #1;
    load_en = 1'b0;
    model[a] = d;
  endtask

  // Idle display sweep: scan position, row contents and quiet status.
  task automatic idle_scan(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge ph1); #1;
      n_cmp++;
      if (row !== 8'(1 << tb_scan)) begin
        n_fail++; $display("FAIL scan_row: got %b expected %b", row, 8'(1 << tb_scan));
      end
      n_cmp++;
      if (col !== model[tb_scan]) begin
        n_fail++; $display("FAIL scan_col r%0d: got %b expected %b", tb_scan, col, model[tb_scan]);
      end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL idle_status: got busy=%b done=%b expected 0/0", busy, done);
      end
      n_cmp++;
      if (gen_count !== 16'(gen_exp) || stable !== stable_exp) begin
        n_fail++; $display("FAIL idle_gen: got gen=%0d stable=%b expected %0d/%b",
                           gen_count, stable, gen_exp, stable_exp);
      end
    end
  endtask

  // One generation with cycle-exact busy/done checks and display checks;
  // optionally injects load_en+step_req during cycle inj_k.
  task automatic run_step(input int inj_k, input logic [2:0] ia, input logic [7:0] id);
    grid_t old_g, new_g;
    logic [7:0] exp_col;
    old_g = model;
    new_g = next_gen(model);
    step_req = 1'b1;
    for (int k = 1; k <= H + 3; k++) begin
      @(posedge ph1); #1;
      if (k == 1) begin step_req = 1'b0; load_en = 1'b0; end
      n_cmp++;
      if (busy !== (k <= H + 1)) begin
        n_fail++; $display("FAIL step_busy k=%0d: got %b expected %b", k, busy, (k <= H + 1));
      end
      n_cmp++;
      if (done !== (k == H + 2)) begin
        n_fail++; $display("FAIL step_done k=%0d: got %b expected %b", k, done, (k == H + 2));
      end
      n_cmp++;
      if (row !== 8'(1 << tb_scan)) begin
        n_fail++; $display("FAIL step_row k=%0d: got %b expected %b", k, row, 8'(1 << tb_scan));
      end
      exp_col = (k <= H + 1) ? old_g[tb_scan] : new_g[tb_scan];
      n_cmp++;
      if (col !== exp_col) begin
        n_fail++; $display("FAIL step_col k=%0d r%0d: got %b expected %b", k, tb_scan, col, exp_col);
      end
      if (k == inj_k) begin
        load_en = 1'b1; load_addr = ia; load_data = id; step_req = 1'b1;
      end else if (k == inj_k + 1) begin
        load_en = 1'b0; step_req = 1'b0;
      end
    end
    model = new_g;
    gen_exp = (gen_exp + 1) % 65536;
    stable_exp = grids_eq(old_g, new_g);
    n_cmp++;
    if (gen_count !== 16'(gen_exp)) begin
      n_fail++; $display("FAIL gen_count: got %0d expected %0d", gen_count, gen_exp);
    end
    n_cmp++;
    if (stable !== stable_exp) begin
      n_fail++; $display("FAIL stable: got %b expected %b", stable, stable_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_en = 1'b0; step_req = 1'b0; load_addr = '0; load_data = '0;
    @(posedge ph1); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || stable !== 1'b0 || gen_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_status: got busy=%b done=%b stable=%b gen=%0d expected 0/0/0/0",
                         busy, done, stable, gen_count);
    end
    n_cmp++;
    if (row !== 8'b0000_0001 || col !== 8'h00) begin
      n_fail++; $display("FAIL reset_display: got row=%b col=%b expected 00000001/00000000", row, col);
    end
    // Reset wins over simultaneous load and step.
    load_en = 1'b1; load_addr = 3'd0; load_data = 8'hFF; step_req = 1'b1;
    @(posedge ph1); #1;
    n_cmp++;
    if (busy !== 1'b0 || col !== 8'h00 || row !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset_priority: got busy=%b row=%b col=%b expected 0/00000001/00000000",
                         busy, row, col);
    end
    reset = 1'b0; load_en = 1'b0; step_req = 1'b0;
    for (int r = 0; r < H; r++) model[r] = '0;
    gen_exp = 0; stable_exp = 1'b0;
    idle_scan(H);
  endtask

  task automatic test_blinker();
    do_reset();
    load_row(3'd3, 8'b0001_1100);
    run_step(0, 3'd0, 8'h00);
    idle_scan(2 * H);
  endtask

  task automatic test_block();
    do_reset();
    load_row(3'd3, 8'b0001_1000);
    load_row(3'd4, 8'b0001_1000);
    run_step(0, 3'd0, 8'h00);
    run_step(0, 3'd0, 8'h00);
    idle_scan(H);
    // A load leaves stable and gen_count alone.
    load_row(3'd0, 8'b1000_0001);
    idle_scan(H);
  endtask

  task automatic test_edge_blinker();
    do_reset();
    load_row(3'd0, 8'b0001_1100);
    run_step(0, 3'd0, 8'h00);
    idle_scan(H);
  endtask

  task automatic test_load_busy();
    do_reset();
    load_row(3'd5, 8'b0010_0100);
    load_row(3'd4, 8'b0110_0000);
    load_row(3'd6, 8'b0000_0110);
    run_step(3, 3'd5, 8'hFF);
    idle_scan(2 * H);
  endtask

  task automatic test_load_and_step();
    do_reset();
    load_row(3'd2, 8'b0111_0000);
    load_en = 1'b1; load_addr = 3'd3; load_data = 8'b0000_1110;
    model[3] = 8'b0000_1110;
    run_step(0, 3'd0, 8'h00);
    idle_scan(H);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < H; r++) load_row(3'(r), 8'($urandom));
    run_step(0, 3'd0, 8'h00);
    step_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge ph1); #1;
      if (k == 1) step_req = 1'b0;
    end
    reset = 1'b1;
    @(posedge ph1); #1;
    reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0) begin
      n_fail++; $display("FAIL midreset_status: got busy=%b done=%b gen=%0d expected 0/0/0",
                         busy, done, gen_count);
    end
    n_cmp++;
    if (row !== 8'b0000_0001 || col !== 8'h00) begin
      n_fail++; $display("FAIL midreset_display: got row=%b col=%b expected 00000001/00000000", row, col);
    end
    for (int r = 0; r < H; r++) model[r] = '0;
    gen_exp = 0; stable_exp = 1'b0;
    idle_scan(H + 4);
  endtask

  task automatic test_random();
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      for (int r = 0; r < H; r++) load_row(3'(r), 8'($urandom));
      for (int g = 0; g < 3; g++) run_step(0, 3'd0, 8'h00);
      idle_scan(H);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_blinker();
    test_block();
    test_edge_blinker();
    test_load_busy();
    test_load_and_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cgol_engine.md
CGOL_ENGINE -- requirements
Module: cgol_engine

Interface
REQ-001 Parameter WIDTH, default 8, shall set the number of columns (cells per row); legal range 3..32.
REQ-002 Parameter HEIGHT, default 8, shall set the number of rows; legal range 3..32.
REQ-003 Parameter REGBITS, default 3, shall set the row-address width and shall be at least ceil(log2(HEIGHT)).
REQ-004 ph1  input  1  sole clock; every register shall update on its rising edge; the block shall have one clock, and reset shall be synchronous and active-high.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  write load_data into current row load_addr.
REQ-007 load_addr  input  REGBITS  row index for the load.
REQ-008 load_data  input  WIDTH  row contents; bit c = column c; 1 = alive.
REQ-009 step_req  input  1  request one generation.
REQ-010 busy  output  1  high while a generation is in progress.
REQ-011 done  output  1  one-cycle pulse when a generation has been committed.
REQ-012 stable  output  1  last committed generation equalled its predecessor.
REQ-013 gen_count  output  16  number of committed generations.
REQ-014 row  output  HEIGHT  one-hot display row select.
REQ-015 col  output  WIDTH  current-state contents of the selected row.

Function
REQ-016 Storage shall be two HEIGHT x WIDTH bit arrays: cur (visible state) and nxt (generation under construction).
REQ-017 The FSM shall have three states: IDLE, COMPUTE and COMMIT.
REQ-018 In IDLE, step_req=1 shall move the FSM to COMPUTE on the next cycle with the row counter at 0; otherwise the FSM shall stay in IDLE.
REQ-019 COMPUTE shall process one row per cycle, rows 0..HEIGHT-1 in order, writing nxt[r] from cur rows r-1, r and r+1; after row HEIGHT-1 the FSM shall go to COMMIT.
REQ-020 COMMIT shall copy nxt into cur, set stable=(nxt==cur), increment gen_count modulo 2^16, and go to IDLE.
REQ-021 done shall be 1 for exactly the first IDLE cycle after COMMIT; with step_req in cycle 0, done shall be high in cycle HEIGHT+2.
REQ-022 busy shall be 1 in COMPUTE and COMMIT and 0 in IDLE.
REQ-023 The cell rule shall be B3/S23: a dead cell with exactly 3 live neighbours shall become alive; a live cell with 2 or 3 live neighbours shall stay alive; every other cell shall be dead.
REQ-024 Neighbour counts shall be 4-bit, range 0..8, and shall never include the cell itself.
REQ-025 Edge-neighbour handling shall be as set by REQ-035 / REQ-036.
REQ-026 A load shall occur only when load_en=1, the FSM is in IDLE and load_addr < HEIGHT; all other load requests shall be ignored silently.
REQ-027 When load_en and step_req are both high in IDLE, both shall be accepted; the generation shall be computed from the loaded data.
REQ-028 step_req while busy shall be ignored and shall not be queued.
REQ-029 A load shall not change stable or gen_count.
REQ-030 The display scan index shall advance by one every cycle, 0..HEIGHT-1, and wrap to 0, independent of FSM state.
REQ-031 row shall be one-hot at the scan index, and col shall equal cur[scan index]; a partially computed generation shall never appear on col.

Reset
REQ-032 While reset=1 at a ph1 edge, all cur and nxt bits shall clear to 0, and the FSM shall go to IDLE.
REQ-033 The same reset shall clear gen_count=0, stable=0, done=0, busy=0, scan index=0 (row=1, col=0), and shall take priority over load_en and step_req.
REQ-034 Reset during COMPUTE or COMMIT shall abandon the generation, with no done pulse and no gen_count increment.

Configuration
REQ-035 When macro CGOL_TORUS_EN is defined, neighbour indices shall wrap modulo HEIGHT and modulo WIDTH, making the grid toroidal.
REQ-036 When CGOL_TORUS_EN is undefined, neighbours outside the grid shall count as dead.

Verification
REQ-037 Blinker (8x8): load row3=0001_1100, then step -> rows 2, 3 and 4 = 0000_1000, all other rows 0; done in cycle 10 after step_req; gen_count=1; stable=0.
REQ-038 Block: load rows 3 and 4 = 0001_1000, then step -> grid unchanged, stable=1; a second step keeps stable=1, gen_count=2.
REQ-039 Edge blinker: load row0=0001_1100, then step -> with CGOL_TORUS_EN, rows 7, 0 and 1 = 0000_1000; without it, rows 0 and 1 = 0000_1000 and row7=0.
REQ-040 Load while busy: pulse load_en with row5=1111_1111 in cycle 3 of COMPUTE -> row5 unchanged after commit; a step_req in the same window does not cause a second generation.
REQ-041 Reset mid-compute: assert reset in cycle 4 after step_req -> next cycle all rows 0, busy=0, no done pulse, gen_count=0, row=0000_0001.
REQ-042 Display scan: for 16 consecutive cycles, row walks 0000_0001..1000_0000 twice, and col matches the loaded cur row every cycle, including while busy.
